// File: rtl/shift_reg_univ.sv
// Universal shift register: load/clear/NOP in one cycle, multi-step shifts and
// rotates one bit per enabled cycle under a valid/ready command handshake.
module shift_reg_univ #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               serial_in,
  output logic [WIDTH-1:0]   data_out,
  output logic               serial_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    M_NOP  = 3'b000,
    M_LOAD = 3'b001,
    M_SLL  = 3'b010,
    M_SRL  = 3'b011,
    M_SRA  = 3'b100,
    M_ROL  = 3'b101,
    M_ROR  = 3'b110,
    M_CLR  = 3'b111
  } mode_e;

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  state_e             r_state, w_next;
  mode_e              r_mode, w_mode_in;
  logic [SHAMT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_data, w_step_data;
  logic               r_sout, w_step_out, r_done;
  logic               w_accept, w_is_shift, w_start_shift, w_last;

  assign w_mode_in     = mode_e'(mode);
  assign w_is_shift    = w_mode_in inside {M_SLL, M_SRL, M_SRA, M_ROL, M_ROR};
  assign w_accept      = cmd_valid & cmd_ready;
  assign w_start_shift = w_accept & w_is_shift & (shamt != '0);
  assign w_last        = (r_cnt == SHAMT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_shift) w_next = S_SHIFT;
      S_SHIFT: if (enable && w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (r_state == S_IDLE) & enable;
    busy      = (r_state == S_SHIFT);
  end

  // One step of the latched shift mode; ROR is the only remaining shift mode.
  always_comb begin
    w_step_data = r_data;
    w_step_out  = r_sout;
    case (r_mode)
      M_SLL: begin
        w_step_data = {r_data[WIDTH-2:0], serial_in};
        w_step_out  = r_data[WIDTH-1];
      end
      M_SRL: begin
        w_step_data = {serial_in, r_data[WIDTH-1:1]};
        w_step_out  = r_data[0];
      end
      M_SRA: begin
        w_step_data = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
        w_step_out  = r_data[0];
      end
      M_ROL: begin
        w_step_data = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
        w_step_out  = r_data[WIDTH-1];
      end
      default: begin
        w_step_data = {r_data[0], r_data[WIDTH-1:1]};
        w_step_out  = r_data[0];
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
      r_sout <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_mode <= M_NOP;
    end else begin
      // done is a single-cycle pulse even when enable is low
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_start_shift) begin
          r_mode <= w_mode_in;
          r_cnt  <= shamt;
        end else if (w_accept) begin
          r_done <= 1'b1;
          if (w_mode_in == M_LOAD)     r_data <= data_in;
          else if (w_mode_in == M_CLR) r_data <= '0;
        end
      end else if (enable) begin
        r_data <= w_step_data;
        r_sout <= w_step_out;
        r_cnt  <= r_cnt - SHAMT_W'(1);
        if (w_last) r_done <= 1'b1;
      end
    end
  end

  assign data_out   = r_data;
  assign serial_out = r_sout;
  assign done       = r_done;

endmodule
